// File: rtl/mem_stage_pkg.sv
// Shared types and widths for the memory-access pipeline stage.
package mem_stage_pkg;

    localparam int unsigned DATA_W     = 48;
    localparam int unsigned REG_ADDR_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } mem_state_t;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Cycle counter that bounds how long an access may wait for mem_ack.
module mem_timeout_ctr #(
    parameter int unsigned TERMINAL = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_c
);

    localparam int unsigned CNT_W = (TERMINAL > 2) ? $clog2(TERMINAL) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear dominates enable.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_c = en_i && (cnt_q == CNT_W'(TERMINAL - 1));

endmodule

// File: rtl/mem_access_stage.sv
// Memory stage: sequences one req/ack data-memory access per load/store,
// stalls the front end meanwhile and aborts hung accesses via a watchdog.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  validE,
    input  logic [DATA_W-1:0]     ALUOutE,
    input  logic [DATA_W-1:0]     WriteDataE,
    input  logic [REG_ADDR_W-1:0] WA3E,
    input  logic                  PCSrcE,
    input  logic                  regWriteE,
    input  logic                  memToRegE,
    input  logic                  memWriteE,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic [DATA_W-1:0]     RD,
    output logic [DATA_W-1:0]     ALUOutM,
    output logic [REG_ADDR_W-1:0] WA3M,
    output logic                  PCSrcM,
    output logic                  regWriteM,
    output logic                  memToRegM,
    output logic                  stallM,
    output logic                  mem_err
);

    mem_state_t state_q, state_d;

    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              abort_q, abort_d;

    logic memop;
    logic ctr_clr;
    logic ctr_en;
    logic ctr_tc;

    assign memop   = validE & (memToRegE | memWriteE);
    assign ctr_en  = (state_q == REQ);
    assign ctr_clr = (state_q != REQ) | mem_ack | ctr_tc;

    mem_timeout_ctr #(
        .TERMINAL (TIMEOUT)
    ) u_timeout_ctr (
        .clk   (clk),
        .rst   (rst),
        .clr_i (ctr_clr),
        .en_i  (ctr_en),
        .tc_c  (ctr_tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus the request/response holding registers.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        abort_d = abort_q;
        case (state_q)
            IDLE: begin
                if (memop) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    we_d    = memWriteE;
                    addr_d  = ALUOutE[ADDR_W-1:0];
                    wdata_d = WriteDataE;
                    abort_d = 1'b0;
                end
            end
            REQ: begin
                // An ack in the terminal cycle still completes normally.
                if (mem_ack) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    rdata_d = memWriteE ? '0 : mem_rdata;
                end else if (ctr_tc) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    rdata_d = '0;
                    err_d   = 1'b1;
                    abort_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            abort_q <= abort_d;
        end
    end

    // MEM/WB-facing outputs; controls become a bubble whenever stalled.
    always_comb begin
        ALUOutM   = ALUOutE;
        WA3M      = WA3E;
        RD        = '0;
        stallM    = 1'b0;
        PCSrcM    = PCSrcE & validE;
        regWriteM = regWriteE & validE;
        memToRegM = memToRegE & validE;
        case (state_q)
            IDLE: begin
                if (memop) begin
                    stallM    = 1'b1;
                    PCSrcM    = 1'b0;
                    regWriteM = 1'b0;
                    memToRegM = 1'b0;
                end
            end
            REQ: begin
                stallM    = 1'b1;
                PCSrcM    = 1'b0;
                regWriteM = 1'b0;
                memToRegM = 1'b0;
            end
            DONE: begin
                RD        = rdata_q;
                regWriteM = regWriteE & validE & ~abort_q;
            end
            default: begin
                stallM = 1'b0;
            end
        endcase
        // Reset must quiet the hazard unit and MEM/WB without waiting for a clock.
        if (!rst) begin
            stallM    = 1'b0;
            PCSrcM    = 1'b0;
            regWriteM = 1'b0;
            memToRegM = 1'b0;
        end
    end

    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_err   = err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: ALU pass-through, load, store,
// ack/timeout race, watchdog abort and asynchronous reset mid-access.
module tb_mem_access_stage;
    import mem_stage_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  validE;
    logic [DATA_W-1:0]     ALUOutE;
    logic [DATA_W-1:0]     WriteDataE;
    logic [REG_ADDR_W-1:0] WA3E;
    logic                  PCSrcE, regWriteE, memToRegE, memWriteE;
    logic                  mem_req, mem_we;
    logic [15:0]           mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic                  mem_ack;
    logic [DATA_W-1:0]     mem_rdata;
    logic [DATA_W-1:0]     RD, ALUOutM;
    logic [REG_ADDR_W-1:0] WA3M;
    logic                  PCSrcM, regWriteM, memToRegM, stallM, mem_err;

    int n_pass  = 0;
    int n_total = 0;
    int n_req;

    always #5 clk = ~clk;

    mem_access_stage #(
        .ADDR_W  (16),
        .TIMEOUT (64)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .validE     (validE),
        .ALUOutE    (ALUOutE),
        .WriteDataE (WriteDataE),
        .WA3E       (WA3E),
        .PCSrcE     (PCSrcE),
        .regWriteE  (regWriteE),
        .memToRegE  (memToRegE),
        .memWriteE  (memWriteE),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .RD         (RD),
        .ALUOutM    (ALUOutM),
        .WA3M       (WA3M),
        .PCSrcM     (PCSrcM),
        .regWriteM  (regWriteM),
        .memToRegM  (memToRegM),
        .stallM     (stallM),
        .mem_err    (mem_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] wd,
                         input logic [REG_ADDR_W-1:0] wa3, input logic pc, input logic rw,
                         input logic m2r, input logic mw);
        validE     = v;
        ALUOutE    = alu;
        WriteDataE = wd;
        WA3E       = wa3;
        PCSrcE     = pc;
        regWriteE  = rw;
        memToRegE  = m2r;
        memWriteE  = mw;
    endtask

    initial begin
        rst       = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset state, including a memop presented while reset is held.
        @(negedge clk);
        drive(1'b1, 48'h40, '0, 4'd1, 1'b1, 1'b1, 1'b1, 1'b0);
        #1;
        chk("rst_stall", 64'(stallM), 64'd0);
        chk("rst_req", 64'(mem_req), 64'd0);
        chk("rst_we", 64'(mem_we), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        chk("rst_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_rd", 64'(RD), 64'd0);
        chk("rst_regwrite", 64'(regWriteM), 64'd0);
        chk("rst_memtoreg", 64'(memToRegM), 64'd0);
        chk("rst_pcsrc", 64'(PCSrcM), 64'd0);
        chk("rst_err", 64'(mem_err), 64'd0);
        @(negedge clk);
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;

        // ALU op passes straight through.
        @(negedge clk);
        drive(1'b1, 48'h123, '0, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        chk("alu_out", 64'(ALUOutM), 64'h123);
        chk("alu_wa3", 64'(WA3M), 64'd5);
        chk("alu_regwrite", 64'(regWriteM), 64'd1);
        chk("alu_pcsrc", 64'(PCSrcM), 64'd1);
        chk("alu_stall", 64'(stallM), 64'd0);
        chk("alu_rd", 64'(RD), 64'd0);
        @(negedge clk);
        chk("alu_noreq", 64'(mem_req), 64'd0);

        // validE=0: controls gated, no request even with memToRegE set.
        drive(1'b0, 48'h777, '0, 4'd9, 1'b1, 1'b1, 1'b1, 1'b0);
        #1;
        chk("inv_pcsrc", 64'(PCSrcM), 64'd0);
        chk("inv_regwrite", 64'(regWriteM), 64'd0);
        chk("inv_stall", 64'(stallM), 64'd0);
        chk("inv_alu", 64'(ALUOutM), 64'h777);
        @(negedge clk);
        chk("inv_noreq", 64'(mem_req), 64'd0);

        // Load, ack in the third REQ cycle: four stall cycles in total.
        drive(1'b1, 48'h0040, '0, 4'd7, 1'b0, 1'b1, 1'b1, 1'b0);
        #1;
        chk("ld_idle_stall", 64'(stallM), 64'd1);
        chk("ld_idle_m2r", 64'(memToRegM), 64'd0);
        chk("ld_idle_rw", 64'(regWriteM), 64'd0);
        chk("ld_idle_req", 64'(mem_req), 64'd0);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            if (i == 3) begin
                mem_ack   = 1'b1;
                mem_rdata = 48'hABCDEF012345;
            end
            #1;
            chk("ld_req", 64'(mem_req), 64'd1);
            chk("ld_addr", 64'(mem_addr), 64'h0040);
            chk("ld_we", 64'(mem_we), 64'd0);
            chk("ld_stall", 64'(stallM), 64'd1);
        end
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = '0;
        #1;
        chk("ld_done_rd", 64'(RD), 64'hABCDEF012345);
        chk("ld_done_m2r", 64'(memToRegM), 64'd1);
        chk("ld_done_rw", 64'(regWriteM), 64'd1);
        chk("ld_done_stall", 64'(stallM), 64'd0);
        chk("ld_done_req", 64'(mem_req), 64'd0);
        chk("ld_done_wa3", 64'(WA3M), 64'd7);

        // Store, ack on the first REQ cycle: two stall cycles, RD stays 0.
        @(negedge clk);
        drive(1'b1, 48'h0080, 48'h5A5A, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        chk("st_idle_stall", 64'(stallM), 64'd1);
        @(negedge clk);
        mem_ack   = 1'b1;
        mem_rdata = 48'hFFFFFFFFFFFF;
        #1;
        chk("st_req", 64'(mem_req), 64'd1);
        chk("st_we", 64'(mem_we), 64'd1);
        chk("st_wdata", 64'(mem_wdata), 64'h5A5A);
        chk("st_addr", 64'(mem_addr), 64'h0080);
        chk("st_stall", 64'(stallM), 64'd1);
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = '0;
        #1;
        chk("st_done_stall", 64'(stallM), 64'd0);
        chk("st_done_rd", 64'(RD), 64'd0);
        chk("st_done_req", 64'(mem_req), 64'd0);

        // Ack lands in the 64th REQ cycle: ack wins over the watchdog.
        @(negedge clk);
        drive(1'b1, 48'h0100, '0, 4'd4, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 1; i <= 64; i++) begin
            @(negedge clk);
            if (i == 64) begin
                mem_ack   = 1'b1;
                mem_rdata = 48'h000013579BDF;
            end
            #1;
            chk("co_req", 64'(mem_req), 64'd1);
        end
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = '0;
        #1;
        chk("co_rd", 64'(RD), 64'h13579BDF);
        chk("co_err", 64'(mem_err), 64'd0);
        chk("co_rw", 64'(regWriteM), 64'd1);
        chk("co_stall", 64'(stallM), 64'd0);

        // Load with no ack: request held exactly 64 cycles, then abort.
        @(negedge clk);
        drive(1'b1, 48'h0200, '0, 4'd6, 1'b0, 1'b1, 1'b1, 1'b0);
        n_req = 0;
        @(negedge clk);
        while (mem_req === 1'b1 && n_req < 200) begin
            n_req = n_req + 1;
            @(negedge clk);
        end
        #1;
        chk("to_req_cycles", 64'(n_req), 64'd64);
        chk("to_err", 64'(mem_err), 64'd1);
        chk("to_rd", 64'(RD), 64'd0);
        chk("to_rw", 64'(regWriteM), 64'd0);
        chk("to_m2r", 64'(memToRegM), 64'd1);
        chk("to_stall", 64'(stallM), 64'd0);
        chk("to_req", 64'(mem_req), 64'd0);
        @(negedge clk);
        drive(1'b1, 48'h55, '0, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        chk("to_sticky_err", 64'(mem_err), 64'd1);
        chk("to_after_rw", 64'(regWriteM), 64'd1);
        @(negedge clk);
        chk("to_sticky_err2", 64'(mem_err), 64'd1);

        // Asynchronous reset in the second REQ cycle.
        drive(1'b1, 48'h0300, '0, 4'd8, 1'b0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        #1;
        chk("rm_req1", 64'(mem_req), 64'd1);
        @(negedge clk);
        #1;
        chk("rm_req2", 64'(mem_req), 64'd1);
        chk("rm_stall2", 64'(stallM), 64'd1);
        #1;
        rst = 1'b0;
        #1;
        chk("rm_req_drop", 64'(mem_req), 64'd0);
        chk("rm_stall_drop", 64'(stallM), 64'd0);
        chk("rm_err_clr", 64'(mem_err), 64'd0);
        @(negedge clk);
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        mem_ack   = 1'b1;
        mem_rdata = 48'h2468;
        #1;
        chk("rm_ack_rd", 64'(RD), 64'd0);
        chk("rm_ack_req", 64'(mem_req), 64'd0);
        chk("rm_ack_stall", 64'(stallM), 64'd0);
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = '0;
        #1;
        chk("rm_post_rd", 64'(RD), 64'd0);
        chk("rm_post_req", 64'(mem_req), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory-stage sequencer between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Drives a req/ack data-memory port for loads and stores, and stalls the front of the pipeline while an access is outstanding.
- Presents RD, ALUOutM, WA3M and the M-stage control bits to MEM/WB. While stalled, those control bits are forced to a bubble.
- Includes a timeout watchdog so a hung memory cannot lock the core.

Parameters:
- DATA_W, 48, width of data words and ALU results.
- ADDR_W, 16, memory address width; taken from ALUOutE[ADDR_W-1:0].
- TIMEOUT, 64, maximum cycles spent in REQ before the access is aborted.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- validE  in  1  EX/MEM register holds a live instruction.
- ALUOutE  in  DATA_W  ALU result; also the memory address.
- WriteDataE  in  DATA_W  store data.
- WA3E  in  4  destination register.
- PCSrcE, regWriteE, memToRegE, memWriteE  in  1 each  control bits from EX/MEM.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  write data.
- mem_ack  in  1  one-cycle completion pulse from memory.
- mem_rdata  in  DATA_W  read data; valid only when mem_ack=1.
- RD  out  DATA_W  load data to MEM/WB.
- ALUOutM  out  DATA_W  ALU result to MEM/WB.
- WA3M  out  4  destination register to MEM/WB.
- PCSrcM, regWriteM, memToRegM  out  1 each  control bits to MEM/WB.
- stallM  out  1  to hazard unit: freeze PC, IF/ID, ID/EX and EX/MEM.
- mem_err  out  1  sticky timeout flag.

Behaviour:
- Reset (rst=0, async): state=IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0; rdata_q=0; timeout counter=0; mem_err=0.
  - Consequence: stallM=0, RD=0, all control outputs 0.
- Memory op is defined as memop = validE & (memToRegE | memWriteE).
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - memop=0: pass-through, combinational. ALUOutM=ALUOutE, WA3M=WA3E, controls = E-bits & validE, RD=0, stallM=0.
  - memop=1: stallM=1 and controls forced 0 this cycle.
  - On the next edge: register mem_addr, mem_wdata, and mem_we=memWriteE; set mem_req=1; go to REQ.
- REQ:
  - stallM=1, controls forced 0. mem_req, mem_we, mem_addr, mem_wdata held stable.
  - Counter increments every cycle.
  - mem_ack=1: capture rdata_q = memWriteE ? 0 : mem_rdata; mem_req=0; counter cleared; go to DONE.
  - Counter reaches TIMEOUT-1 without ack: mem_req=0; rdata_q=0; mem_err=1 (sticky until reset); go to DONE.
  - If ack and timeout occur in the same cycle, ack wins and mem_err is not set.
- DONE:
  - stallM=0; RD=rdata_q. ALUOutM, WA3M and controls come from the still-frozen EX/MEM inputs.
  - After a timeout abort, regWriteM is forced 0.
  - Next edge returns to IDLE. DONE never issues a new request, so back-to-back memops cost one IDLE cycle each.
- Latency for a memory op: stall cycles = 1 + ack wait (minimum 2); result appears in the DONE cycle.
- Non-memory ops have zero added latency.
- mem_ack while in IDLE or DONE is ignored.
- validE=0 in IDLE: controls 0, no request issued.
- Reset mid-REQ: mem_req drops immediately and asynchronously; any later ack is ignored.

Decomposition:
- Shared package mem_stage_pkg holds:
  - typedef mem_state_t {IDLE, REQ, DONE};
  - localparams DATA_W=48 and REG_ADDR_W=4.
- One sub-module, mem_timeout_ctr: counter with clear and enable inputs and a terminal-count output. It shares clk and rst.

Test Plan:
- ALU op: validE=1, memops 0, ALUOutE=48'h123, WA3E=5, regWriteE=1.
  - Expect in the same cycle: ALUOutM=48'h123, WA3M=5, regWriteM=1, stallM=0, mem_req never 1.
- Load: memToRegE=1, ALUOutE=16'h0040, ack after 3 cycles with mem_rdata=48'hABCDEF012345.
  - Expect: mem_req high 3 cycles with mem_addr=16'h0040, mem_we=0, stallM=1 for 4 cycles.
  - Then the DONE cycle shows RD=48'hABCDEF012345, memToRegM=1, stallM=0.
- Store: memWriteE=1, WriteDataE=48'h5A5A, ack on the first REQ cycle.
  - Expect: mem_we=1, mem_wdata=48'h5A5A, total stall 2 cycles, RD=0 in DONE, mem_req=0 after ack.
- Timeout: load with no ack, TIMEOUT=64.
  - Expect: mem_req high exactly 64 cycles, then mem_err=1; DONE with RD=0 and regWriteM=0.
  - mem_err stays 1 across later ops until reset.
- Reset mid-access: assert rst=0 in the 2nd REQ cycle.
  - Expect: mem_req and stallM fall immediately.
  - After release, an ack pulse in IDLE produces no output change.
- Ack and timeout coincide: ack in the 64th REQ cycle.
  - Expect: RD=mem_rdata and mem_err stays 0.
